shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//   Round-robin arbiter that shares one DATA_W-bit holding register among NUM_REQ
//   requesters and presents the captured word to a single consumer.
//   - Each requester offers a word with a valid/ready handshake.
//   - The block grants one requester, latches its word and tags it with the source index.
//   - The word is held on out_data until the consumer accepts it.
//   - Sits between the producer ports and the downstream register/datapath stage.
// PARAMETERS
//   NUM_REQ  4   number of requesters (2..16)
//   DATA_W   32  width of each data word
//   SRC_W    2   width of out_src; must equal $clog2(NUM_REQ)
// PORTS
//   clk        in   1               clock, all state on rising edge
//   rst_n      in   1               reset, asynchronous, active-low
//   req_valid  in   NUM_REQ         bit i: requester i offers a word
//   req_data   in   NUM_REQ*DATA_W  word i at bits [i*DATA_W +: DATA_W]
//   req_ready  out  NUM_REQ         bit i: word i is accepted this cycle
//   out_valid  out  1               holding register contains an unconsumed word
//   out_data   out  DATA_W          held word
//   out_src    out  SRC_W           index of the requester that supplied out_data
//   out_ready  in   1               consumer accepts the held word this cycle
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=EMPTY, out_valid=0, out_data=0, out_src=0, rr_ptr=0.
//     - req_ready=0 while rst_n=0.
//   States:
//     - EMPTY: nothing held.
//     - FULL: a word is held; out_valid=1 exactly in FULL.
//   Slot free:
//     - can_load = (state==EMPTY) | (state==FULL & out_ready).
//   Arbitration:
//     - Combinational round-robin over req_valid.
//     - Search starts at rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//     - The first set bit wins; at most one grant.
//   Ready:
//     - req_ready[i] = can_load & grant[i].
//     - Combinational from req_valid/out_ready/state; at most one bit set (one-hot or zero).
//     - Producers must hold req_data[i] and req_valid[i] until req_ready[i] is seen.
//   Capture (any req_ready set):
//     - out_data<=word, out_src<=i, rr_ptr<=(i+1)%NUM_REQ, state<=FULL.
//     - Latency: accepted word appears on out_data/out_valid in the next cycle.
//   Consume without refill (FULL & out_ready & no req_valid):
//     - state<=EMPTY, out_valid<=0.
//     - out_data and out_src keep their last values.
//   Consume with refill (FULL & out_ready & some req_valid):
//     - Handoff and new capture happen in the same cycle; state stays FULL.
//     - Sustained throughput is 1 word/clk.
//   Stall (FULL & !out_ready):
//     - All req_ready=0.
//     - out_data, out_src and rr_ptr are held stable.
//   No grant:
//     - rr_ptr changes only on a capture.
//   Pointer wrap:
//     - A grant to index NUM_REQ-1 sets rr_ptr=0.
//   Fairness:
//     - With all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1.
//     - Each requester waits at most NUM_REQ-1 captures.
//   Reset mid-operation:
//     - A held word is discarded; outputs return to reset values immediately.
//     - No handshake completes in the reset cycle.
//   Undefined inputs:
//     - X on req_valid is a bench error; the RTL need not tolerate it.
// TESTING
//   T1 reset: rst_n=0 mid-FULL -> out_valid=0, out_data=0, out_src=0, req_ready=0 that cycle.
//   T2 single: req_valid=4'b0100, data2=32'hDEAD_BEEF, out_ready=0.
//      -> req_ready=4'b0100 for 1 cycle.
//      -> next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_src=2.
//      -> out_data held stable until out_ready.
//   T3 fairness: all 4 valid, out_ready=1 constantly.
//      -> one capture per clk; out_src sequence 0,1,2,3,0 (wrap).
//   T4 stall: FULL, out_ready=0 for 5 clk with req_valid=4'b1111.
//      -> req_ready=0 throughout; out_data unchanged.
//   T5 refill: FULL src=1; out_ready=1 with req_valid=4'b1001.
//      -> same cycle req_ready=4'b1000; next cycle out_src=3; out_valid never drops.
//   T6 drain: FULL, out_ready=1, req_valid=0.
//      -> next cycle out_valid=0, rr_ptr unchanged.
//      -> next grant still follows the round-robin order.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one holding register among NUM_REQ producers.
// Captured word is tagged with its source index and held until consumed.
module shared_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic              state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;

    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               grant_any;
    logic [SRC_W:0]     scan_sum;
    logic [SRC_W-1:0]   scan_idx;
    logic               can_load;
    logic               load;

    // Scan from ptr_q upward, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (scan_sum >= (SRC_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[SRC_W-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any         = 1'b1;
                grant_idx         = scan_idx;
                grant[scan_idx]   = 1'b1;
            end
        end
    end

    always_comb begin
        can_load  = (state_q == ST_EMPTY) || out_ready;
        load      = rst_n && can_load && grant_any;
        req_ready = (rst_n && can_load) ? grant : '0;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (load) begin
            state_d = ST_FULL;
            data_d  = req_data[grant_idx*DATA_W +: DATA_W];
            src_d   = grant_idx;
            if (32'(grant_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SRC_W'(1);
            end
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed vector table, hand sequences
// and randomized traffic against a cycle-level reference model.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_src;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .SRC_W(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_src  (out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] v;
        logic         ordy;
        logic [N-1:0] rdy;
        logic         ov;
        logic [S-1:0] src;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // reference model state
    bit       m_full;
    int       m_src;
    int       m_ptr;
    bit [W-1:0] m_data;

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[3]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2};
        tbl[4]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd3};
        tbl[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
        tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
        tbl[10] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
        tbl[11] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // reset state, with requests pending
        #12;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_src", 32'(out_src), 32'h0);
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // directed table
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA000_0000 + i;
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].v;
            out_ready = tbl[i].ordy;
            #3;
            chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_src", i), 32'(out_src), 32'(tbl[i].src));
            if (i > 0) begin
                chk($sformatf("tbl%0d_data", i), out_data,
                    32'hA000_0000 + 32'(tbl[i].src));
            end
            next_cycle();
        end

        // single capture of DEAD_BEEF from requester 2 (pointer is at 1)
        req_data[2*W +: W] = 32'hDEAD_BEEF;
        req_valid = 4'b0100;
        out_ready = 1'b0;
        #3;
        chk("single_ready", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = '0;
        #3;
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", out_data, 32'hDEAD_BEEF);
        chk("single_src", 32'(out_src), 32'h2);
        next_cycle();

        // stall with everyone requesting
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk($sformatf("stall%0d_ready", c), 32'(req_ready), 32'h0);
            chk($sformatf("stall%0d_data", c), out_data, 32'hDEAD_BEEF);
            chk($sformatf("stall%0d_valid", c), 32'(out_valid), 32'h1);
            next_cycle();
        end

        // reset while FULL
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", out_data, 32'h0);
        chk("midrst_src", 32'(out_src), 32'h0);
        req_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        #3;
        chk("postrst_valid", 32'(out_valid), 32'h0);
        next_cycle();

        // randomized traffic against the reference model
        m_full = 1'b0;
        m_src  = 0;
        m_ptr  = 0;
        m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            int           g;
            bit [N-1:0]   e_rdy;
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            e_rdy = '0;
            if (g >= 0 && (!m_full || out_ready)) e_rdy[g] = 1'b1;
            chk("rnd_ready", 32'(req_ready), 32'(e_rdy));
            chk("rnd_valid", 32'(out_valid), 32'(m_full));
            chk("rnd_src", 32'(out_src), 32'(m_src));
            chk("rnd_data", out_data, m_data);
            if (e_rdy != 0) begin
                m_full = 1'b1;
                m_src  = g;
                m_data = req_data[g*W +: W];
                m_ptr  = (g + 1) % N;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
